// File: rtl/nrisc_mem_arbiter.sv
// rtl/nrisc_mem_arbiter.sv - round-robin arbiter sharing the NRISC data memory between CPU and external port
module nrisc_mem_arbiter #(
  parameter int TAM     = 16,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cpu_req,
  input  logic           cpu_write,
  input  logic [TAM-1:0] cpu_addr,
  input  logic [TAM-1:0] cpu_wdata,
  output logic [TAM-1:0] cpu_rdata,
  output logic           cpu_ack,
  input  logic           ext_req,
  input  logic           ext_write,
  input  logic [TAM-1:0] ext_addr,
  input  logic [TAM-1:0] ext_wdata,
  output logic [TAM-1:0] ext_rdata,
  output logic           ext_ack,
  output logic [TAM-1:0] mem_addr,
  output logic [TAM-1:0] mem_wdata,
  output logic           mem_write,
  output logic           mem_load,
  input  logic [TAM-1:0] mem_rdata,
  output logic           busy,
  output logic           owner
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic       last;
  logic       lat_write;
  logic [3:0] cnt;
  logic       grant_ext;

  // last=1 after reset so a tie on the very first request goes to the CPU
  assign grant_ext = ext_req & (~cpu_req | ~last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      lat_write <= 1'b0;
      cnt       <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req | ext_req) begin
            owner     <= grant_ext;
            lat_write <= grant_ext ? ext_write : cpu_write;
            mem_addr  <= grant_ext ? ext_addr  : cpu_addr;
            mem_wdata <= grant_ext ? ext_wdata : cpu_wdata;
            cnt       <= CNT_INIT;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (lat_write) begin
            state <= S_DONE;
          end else if (cnt == 4'd0) begin
            if (owner) ext_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          last  <= owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are pure decodes of registered state so async reset drops them at once
  assign mem_write = (state == S_ACCESS) &  lat_write;
  assign mem_load  = (state == S_ACCESS) & ~lat_write;
  assign cpu_ack   = (state == S_DONE)   & ~owner;
  assign ext_ack   = (state == S_DONE)   &  owner;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_nrisc_mem_arbiter.sv
// tb/tb_nrisc_mem_arbiter.sv - scoreboard bench for nrisc_mem_arbiter
module tb_nrisc_mem_arbiter;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_ack;
  logic        ext_req = 1'b0, ext_write = 1'b0;
  logic [15:0] ext_addr = '0, ext_wdata = '0, ext_rdata;
  logic        ext_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_load, busy, owner;

  nrisc_mem_arbiter #(.TAM(16), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ext_req(ext_req), .ext_write(ext_write), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_load(mem_load),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  int          load_cnt = 0;
  logic        prev_write = 1'b0;
  logic [15:0] exp_cpu_rd = '0, exp_ext_rd = '0;
  logic [15:0] mem [0:65535];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: correct data only on the MEM_LAT-th load cycle
  assign mem_rdata = (mem_load && load_cnt == L - 1) ? mem[mem_addr] : 16'hDEAD;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mem[16'h0040] <= 16'hBEEF;
      load_cnt      <= 0;
      prev_write    <= 1'b0;
    end else begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_write && prev_write) chk("write_len", 32'd2, 32'd1);
      if (!mem_load && load_cnt != 0) chk("load_len", load_cnt, L);
      load_cnt   <= mem_load ? load_cnt + 1 : 0;
      prev_write <= mem_write;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_write && mem_load) chk("strobe_excl", 32'd1, 32'd0);
      if (mem_write || mem_load) begin
        if (q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
        else begin
          chk("strobe_kind", mem_write, q[0].wr);
          chk("mem_addr", mem_addr, q[0].addr);
          if (mem_write) chk("mem_wdata", mem_wdata, q[0].data);
        end
      end
      if (cpu_ack || ext_ack) begin
        chk("ack_single", cpu_ack & ext_ack, 32'd0);
        if (q.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("ack_port", ext_ack, e.port);
          chk("owner", owner, e.port);
          chk("busy_done", busy, 32'd1);
          if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
          if (!e.wr) begin
            if (e.port) exp_ext_rd = e.data;
            else        exp_cpu_rd = e.data;
          end
          chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
          chk("ext_rdata", ext_rdata, exp_ext_rd);
        end
      end
    end
  end

  task automatic push(input logic port, input logic wr, input logic [15:0] a,
                      input logic [15:0] d, input int c);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = a; e.data = d; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic wait_ack(input logic port);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(port ? ext_ack : cpu_ack) && k < 60);
    if (k >= 60) chk("ack_timeout", 32'd1, 32'd0);
  endtask

  task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [15:0] d);
    cpu_write = wr; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    wait_ack(1'b0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic ext_access(input logic wr, input logic [15:0] a, input logic [15:0] d);
    ext_write = wr; ext_addr = a; ext_wdata = d; ext_req = 1'b1;
    wait_ack(1'b1);
    @(posedge clk); #1;
    ext_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_strobes", {mem_write, mem_load, cpu_ack, ext_ack}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", {cpu_rdata, ext_rdata}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Both ports requesting continuously: first tie to CPU, then alternate
    @(posedge clk); #1; n = cyc;
    push(0, 1, 16'h0010, 16'h1111, n + 2);
    push(1, 1, 16'h0020, 16'h3333, n + 5);
    push(0, 1, 16'h0011, 16'h2222, n + 8);
    push(1, 1, 16'h0021, 16'h4444, n + 11);
    fork
      begin cpu_access(1, 16'h0010, 16'h1111); cpu_access(1, 16'h0011, 16'h2222); end
      begin ext_access(1, 16'h0020, 16'h3333); ext_access(1, 16'h0021, 16'h4444); end
    join
    repeat (2) @(posedge clk);

    // Single CPU read
    @(posedge clk); #1; n = cyc;
    push(0, 0, 16'h0040, 16'hBEEF, n + 1 + L);
    cpu_access(0, 16'h0040, 16'h0000);
    @(posedge clk);

    // External write then external read-back
    @(posedge clk); #1; n = cyc;
    push(1, 1, 16'h0100, 16'h1234, n + 2);
    ext_access(1, 16'h0100, 16'h1234);
    @(posedge clk); #1; n = cyc;
    push(1, 0, 16'h0100, 16'h1234, n + 1 + L);
    ext_access(0, 16'h0100, 16'h0000);
    @(posedge clk);

    // CPU back-to-back reads with ext_req held; ext access slots in between
    @(posedge clk); #1; n = cyc;
    push(0, 0, 16'h0011, 16'h2222, n + 1 + L);
    push(1, 1, 16'h0030, 16'h5555, n + 6);
    push(0, 0, 16'h0040, 16'hBEEF, n + 8 + L);
    fork
      begin cpu_access(0, 16'h0011, 16'h0000); cpu_access(0, 16'h0040, 16'h0000); end
      ext_access(1, 16'h0030, 16'h5555);
    join
    @(posedge clk);

    // Reset in the 2nd load cycle of a read; request stays high and is redone
    @(posedge clk); #1;
    push(0, 0, 16'h0020, 16'h3333, -1);
    cpu_write = 1'b0; cpu_addr = 16'h0020; cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_load", mem_load, 1);
    rst = 1'b1;
    #1;
    chk("arst_strobes", {mem_write, mem_load, cpu_ack, ext_ack}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_owner", owner, 0);
    chk("arst_mem", {mem_addr, mem_wdata}, 0);
    chk("arst_rdata", {cpu_rdata, ext_rdata}, 0);
    exp_cpu_rd = '0; exp_ext_rd = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q[0].cyc = cyc + 1 + L;
    wait_ack(1'b0);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("idle_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
